// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with frame-synchronous
// commit of staged display data and a per-slot anode guard interval.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP_IN,
    input  logic [3:0]  DIGIT_EN,
    input  logic        BLANK_LZ,
    input  logic        LOAD,
    output logic        ACK,
    output logic        FRAME,
    output logic [7:0]  SEG,
    output logic [3:0]  AN
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blz;
    } disp_t;

    function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    disp_t            staged_q, staged_d;
    disp_t            shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic             frame_q, frame_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic       slot_end;
    logic       boundary;
    logic       commit;
    logic [3:0] lz_zero;
    logic [3:0] nibble;
    logic       lit;

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        boundary = slot_end && (idx_q == 2'd3);
        commit   = boundary && pending_q;

        cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = slot_end ? idx_q + 2'd1 : idx_q;

        // Commit takes the staged set as it was before this edge; a LOAD in
        // the same cycle refills staged and keeps pending set for next frame.
        shadow_d  = commit ? staged_q : shadow_q;
        staged_d  = LOAD ? disp_t'({DATA, DP_IN, DIGIT_EN, BLANK_LZ}) : staged_q;
        pending_d = LOAD ? 1'b1 : (commit ? 1'b0 : pending_q);
        ack_d     = commit;
        frame_d   = boundary;
    end

    always_comb begin
        // lz_zero[i]: nibbles i..3 of the displayed value are all zero
        lz_zero[3] = (shadow_q.data[15:12] == 4'h0);
        lz_zero[2] = lz_zero[3] && (shadow_q.data[11:8] == 4'h0);
        lz_zero[1] = lz_zero[2] && (shadow_q.data[7:4] == 4'h0);
        lz_zero[0] = 1'b0;

        nibble = shadow_q.data[{idx_q, 2'b00} +: 4];
        lit    = (cnt_q >= GUARD_C) && shadow_q.en[idx_q]
                 && !(shadow_q.blz && lz_zero[idx_q]);

        an_d  = 4'hF;
        seg_d = 8'hFF;
        if (lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = {~shadow_q.dp[idx_q], ~hex_pattern(nibble)};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            staged_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= 8'hFF;
            an_q      <= 4'hF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            staged_q  <= staged_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign ACK   = ack_q;
    assign FRAME = frame_q;
    assign SEG   = seg_q;
    assign AN    = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-level reference model plus hand-derived
// display vectors and corner-case sequences.
module tb_seg7_scan_ctrl;

    localparam int RD        = 8;
    localparam int GD        = 2;
    localparam int FRAME_LEN = 4 * RD;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] DATA = '0;
    logic [3:0]  DP_IN = '0;
    logic [3:0]  DIGIT_EN = '0;
    logic        BLANK_LZ = 1'b0;
    logic        LOAD = 1'b0;
    logic        ACK;
    logic        FRAME;
    logic [7:0]  SEG;
    logic [3:0]  AN;

    seg7_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .DP_IN(DP_IN),
        .DIGIT_EN(DIGIT_EN), .BLANK_LZ(BLANK_LZ), .LOAD(LOAD),
        .ACK(ACK), .FRAME(FRAME), .SEG(SEG), .AN(AN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blz;
    } disp_t;

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic            blz;
        logic [3:0][7:0] exp_seg;   // 8'hFF means the digit never lights
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state: cycles since reset, staged/pending/shadow sets
    int         m_t = 0;
    logic       m_pend = 1'b0;
    disp_t      m_stg = '0;
    disp_t      m_shd = '0;
    logic [6:0] pat_tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [15:0] d,
                        input logic [3:0] dp, input logic [3:0] en, input logic blz);
        logic [7:0] es;
        logic [3:0] ea;
        logic       eack, efr, lit;
        logic [3:0] nib;
        int         pos, dig, sub;
        RESET = rst; LOAD = ld; DATA = d; DP_IN = dp; DIGIT_EN = en; BLANK_LZ = blz;
        es = 8'hFF; ea = 4'hF; eack = 1'b0; efr = 1'b0;
        if (rst) begin
            m_t = 0; m_pend = 1'b0; m_stg = '0; m_shd = '0;
        end else begin
            pos = m_t % FRAME_LEN;
            dig = pos / RD;
            sub = pos % RD;
            nib = 4'((int'(m_shd.data) >> (4 * dig)) & 15);
            lit = (sub >= GD) && m_shd.en[dig]
                  && !(m_shd.blz && dig > 0 && (int'(m_shd.data) >> (4 * dig)) == 0);
            if (lit) begin
                ea = ~(4'b0001 << dig);
                es = {~m_shd.dp[dig], ~pat_tbl[nib]};
            end
            efr  = (pos == FRAME_LEN - 1);
            eack = efr && m_pend;
            if (eack) begin m_shd = m_stg; m_pend = 1'b0; end
            if (ld) begin m_stg = '{d, dp, en, blz}; m_pend = 1'b1; end
            m_t++;
        end
        @(posedge CLK);
        #1;
        chk("model_seg", SEG, es);
        chk("model_an", AN, ea);
        chk("model_ack", ACK, eack);
        chk("model_frame", FRAME, efr);
        RESET = 1'b0;
        LOAD = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic sync_to(input int p);
        for (int i = 0; i < FRAME_LEN && (m_t % FRAME_LEN) != p; i++) idle();
    endtask

    vec_t vecs [5];
    int   n_ack, n_lit, bad;
    logic got;
    logic [7:0] seen [4];
    int   lit_cnt [4];

    initial begin
        pat_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0] = '{16'h12AF, 4'b0100, 4'hF, 1'b0, 32'hF9_24_88_8E};
        vecs[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 32'hFF_FF_92_C0};
        vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 32'hFF_FF_FF_C0};
        vecs[3] = '{16'h1234, 4'b0000, 4'b0001, 1'b0, 32'hFF_FF_FF_99};
        vecs[4] = '{16'h2222, 4'b0000, 4'hF, 1'b0, 32'hA4_A4_A4_A4};

        // Reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        chk("rst_an", AN, 4'hF);
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_ack", ACK, 1'b0);
        chk("rst_frame", FRAME, 1'b0);

        // First FRAME pulse position after release
        n_lit = 0; got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            idle();
            if (FRAME) begin got = 1'b1; n_lit = i; end
        end
        chk("first_frame_cycle", n_lit, 32);

        // Table-driven display vectors
        foreach (vecs[v]) begin
            sync_to(5);
            step(1'b0, 1'b1, vecs[v].data, vecs[v].dp, vecs[v].en, vecs[v].blz);
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                idle();
                if (ACK) got = 1'b1;
            end
            chk("vec_ack_seen", got, 1'b1);
            bad = 0;
            for (int d = 0; d < 4; d++) begin seen[d] = 8'hFF; lit_cnt[d] = 0; end
            for (int i = 0; i < FRAME_LEN; i++) begin
                idle();
                if (AN !== 4'hF) begin
                    got = 1'b0;
                    for (int d = 0; d < 4; d++)
                        if (AN === ~(4'b0001 << d)) begin
                            seen[d] = SEG; lit_cnt[d]++; got = 1'b1;
                        end
                    if (!got) bad++;
                end
            end
            chk("vec_an_onehot", bad, 0);
            for (int d = 0; d < 4; d++) begin
                if (vecs[v].exp_seg[d] == 8'hFF) begin
                    chk("vec_digit_dark", lit_cnt[d], 0);
                end else begin
                    chk("vec_digit_lit_cycles", lit_cnt[d], RD - GD);
                    chk("vec_digit_seg", seen[d], vecs[v].exp_seg[d]);
                end
            end
        end

        // Overwrite before boundary: one ACK, newest value shown
        sync_to(2);
        step(1'b0, 1'b1, 16'h1111, 4'h0, 4'hF, 1'b0);
        idle();
        step(1'b0, 1'b1, 16'h3456, 4'h0, 4'hF, 1'b0);
        n_ack = 0; bad = 0;
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            idle();
            if (ACK) n_ack++;
            if (AN === 4'b1110 && n_ack > 0 && SEG !== 8'h82) bad++;
        end
        chk("overwrite_ack_count", n_ack, 1);
        chk("overwrite_digit0_seg", bad, 0);

        // LOAD in the boundary cycle with nothing pending
        sync_to(FRAME_LEN - 1);
        step(1'b0, 1'b1, 16'h3333, 4'h0, 4'hF, 1'b0);
        chk("collide_ack_now", ACK, 1'b0);
        chk("collide_frame_now", FRAME, 1'b1);
        n_ack = 0;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            idle();
            if (ACK) n_ack++;
        end
        chk("collide_no_early_ack", n_ack, 0);
        idle();
        chk("collide_ack_next_frame", ACK, 1'b1);
        n_lit = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            idle();
            if (AN === 4'b0111 && SEG === 8'hB0) n_lit++;
        end
        chk("collide_digit3_shows_3", n_lit, RD - GD);

        // Reset while a load is pending
        sync_to(1);
        step(1'b0, 1'b1, 16'hBEEF, 4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        n_ack = 0; n_lit = 0;
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
            idle();
            if (ACK) n_ack++;
            if (AN !== 4'hF) n_lit++;
        end
        chk("rstpend_no_ack", n_ack, 0);
        chk("rstpend_dark", n_lit, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [15:0] d;
            r = $urandom_range(0, 299);
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = d & 16'(32'hFFFF >> (4 * $urandom_range(0, 4)));
            step(r == 0, r < 25, d, 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Scan controller for the board's 4-digit common-anode seven-segment display. Takes a 16-bit hex value plus per-digit decimal-point and enable masks through a load strobe, stages it, and commits it only at a frame boundary so a displayed frame never tears. Time-multiplexes the shared SEG bus across the four anodes, with a guard interval between digits to suppress ghosting. Sits between switch/register logic and the SEG/AN board pins.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- GUARD, 2: cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-2.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA  in  16  hex value; nibble i drives digit i (digit 0 = rightmost).
- DP_IN  in  4  decimal-point request per digit, active-high.
- DIGIT_EN  in  4  per-digit enable, active-high.
- BLANK_LZ  in  1  leading-zero suppression enable.
- LOAD  in  1  one-cycle strobe; samples DATA, DP_IN, DIGIT_EN, BLANK_LZ.
- ACK  out  1  one-cycle pulse when a staged load is committed to display.
- FRAME  out  1  one-cycle pulse when scanning wraps back to digit 0.
- SEG  out  8  active-low; SEG[0..6] = segments a..g, SEG[7] = DP.
- AN  out  4  active-low anode enables; AN[i] = digit i.

## Operation
- Registers: staged set (16+4+4+1 bits), pending flag, shadow set (same width, drives display), prescaler cnt (0..REFRESH_DIV-1), digit index idx (0..3).
- cnt increments every cycle; at REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0.
- Frame boundary: cycle with cnt==REFRESH_DIV-1 and idx==3.
- LOAD: staged <= inputs, pending <= 1. LOAD while pending overwrites the staged set; only the newest value is committed, and a single ACK is produced.
- At a frame boundary with pending==1 (pending already set before that cycle): shadow <= staged, pending <= 0, ACK pulses.
- LOAD in the boundary cycle itself: the new value is staged, pending stays/becomes 1, and it commits at the next boundary. If pending was already 1, the value committed at this boundary is the previous staged set; the new LOAD overwrites staged in the same edge.
- Digit i is lit when cnt >= GUARD, DIGIT_EN_shadow[i]==1, and digit i is not LZ-blanked.
- LZ blanking (BLANK_LZ_shadow==1): digit i (i=3,2,1) is blanked when nibbles i..3 are all zero; digit 0 is never blanked.
- Lit digit: AN = one-hot-low on idx; SEG[6:0] = ~pattern(nibble), SEG[7] = ~DP_shadow[idx]. Unlit: AN = 4'hF, SEG = 8'hFF.
- Patterns (gfedcba, active-high hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

## Timing
- All outputs registered: SEG/AN at edge t+1 reflect cnt/idx/shadow at cycle t.
- Reset values: AN=4'hF, SEG=8'hFF, ACK=0, FRAME=0, cnt=0, idx=0, pending=0, staged=0, shadow=0 (DIGIT_EN_shadow=0, so display dark until the first commit).
- ACK and FRAME are both asserted on the cycle after the boundary cycle; they coincide when a commit occurs.
- Worst-case LOAD→ACK latency: 4·REFRESH_DIV+1 cycles; best case: 2 cycles (LOAD one cycle before the boundary).
- RESET mid-operation: all state returns to reset values on that edge. A pending load is discarded and no ACK is produced. LOAD in the same cycle as RESET is ignored.
- Each digit is lit for REFRESH_DIV-GUARD cycles per slot; frame period is 4·REFRESH_DIV cycles.

## Test plan
(REFRESH_DIV=8, GUARD=2)
- Reset: hold RESET for 3 cycles -> AN=F, SEG=FF, ACK=0, FRAME=0; FRAME first pulses 32 cycles after RESET release.
- Basic load: LOAD DATA=16'h12AF, DP_IN=4'b0100, DIGIT_EN=F, BLANK_LZ=0 -> one ACK at the next boundary. In the next frame: digit0 SEG=8'h8E, digit1 SEG=8'h88, digit2 SEG=8'h24 (DP on), digit3 SEG=8'hF9. AN is F during the 2 guard cycles of each slot, then E, D, B, 7 in turn.
- Overwrite: LOAD 16'h1111, then LOAD 16'h2222 before the boundary -> exactly one ACK; display shows 2222.
- Boundary collision: LOAD 16'h3333 in the boundary cycle, with pending=0 -> no ACK that frame; ACK and commit of 3333 one frame later.
- LZ/enable: LOAD DATA=16'h0050, BLANK_LZ=1, DIGIT_EN=F -> digits 3 and 2 dark, digits 1 and 0 show 5 and 0. LOAD DATA=16'h0000 -> only digit 0 lit, showing 0. DIGIT_EN=4'b0001 -> only AN[0] ever goes low.
- Reset mid-pending: LOAD 16'hBEEF, then RESET before the boundary -> no ACK; display stays dark through the following frames.
